// File: rtl/data_path.sv
// data_path -- execution datapath of the K&S processor (control-unit responder).
//
// Holds PC (5b), IR (16b), a 4 x 16-bit register file and the flags register,
// drives the RAM address/data buses and returns the decoded instruction plus
// the registered flags to the control unit.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   branch                PC load source: 1 = IR[4:0], 0 = PC+1
//   pc_enable             PC update strobe
//   ir_enable             IR <= data_in
//   write_reg_enable      register-file write strobe
//   addr_sel              ram_addr source: 0 = PC, 1 = IR[4:0]
//   c_sel                 register write source: 1 = ALU, 0 = data_in
//   operation[1:0]        ALU op: 00 OR, 01 ADD, 10 SUB, 11 AND
//   flags_reg_enable      flags register update strobe
//   data_in[15:0]         RAM read data
//   ram_addr[4:0]         RAM address
//   data_out[15:0]        RAM write data = R[IR[6:5]]
//   decoded_instruction   decode of IR
//   zero_op, neg_op, unsigned_overflow, signed_overflow   registered flags
//
// Build option: define DATA_PATH_R0_ZERO_EN to hardwire R0 to zero.

package k_and_s_pkg;
    typedef enum logic [3:0] {
        I_NOP, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR,
        I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV, I_HALT
    } decoded_instruction_type;
endpackage

module data_path
    import k_and_s_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    branch,
    input  logic                    pc_enable,
    input  logic                    ir_enable,
    input  logic                    write_reg_enable,
    input  logic                    addr_sel,
    input  logic                    c_sel,
    input  logic [1:0]              operation,
    input  logic                    flags_reg_enable,
    input  logic [15:0]             data_in,
    output logic [4:0]              ram_addr,
    output logic [15:0]             data_out,
    output decoded_instruction_type decoded_instruction,
    output logic                    zero_op,
    output logic                    neg_op,
    output logic                    unsigned_overflow,
    output logic                    signed_overflow
);

    logic [4:0]  pc;
    logic [15:0] ir;
    logic [15:0] regs [4];

    logic [15:0] a_op, b_op, alu_res;
    logic [16:0] sum, diff;
    logic        alu_uov, alu_sov;
    logic [1:0]  wr_idx;
    logic [15:0] wr_data;

    // Register read port; R0 optionally reads as constant zero.
    function automatic logic [15:0] rd(input logic [1:0] idx, input logic [15:0] v);
`ifdef DATA_PATH_R0_ZERO_EN
        return (idx == 2'd0) ? 16'h0000 : v;
`else
        return (idx == 2'd0) ? v : v;
`endif
    endfunction

    // ---------------- decode ----------------
    always_comb begin
        decoded_instruction = I_NOP;
        case (ir[15:8])
            8'h01: decoded_instruction = I_LOAD;
            8'h02: decoded_instruction = I_STORE;
            8'h03: decoded_instruction = I_MOVE;
            8'h04: decoded_instruction = I_ADD;
            8'h05: decoded_instruction = I_SUB;
            8'h06: decoded_instruction = I_AND;
            8'h07: decoded_instruction = I_OR;
            8'h08: decoded_instruction = I_BRANCH;
            8'h09: decoded_instruction = I_BZERO;
            8'h0A: decoded_instruction = I_BNZERO;
            8'h0B: decoded_instruction = I_BNEG;
            8'h0C: decoded_instruction = I_BNNEG;
            8'h0D: decoded_instruction = I_BOV;
            8'h0E: decoded_instruction = I_BNOV;
            8'hFF: decoded_instruction = I_HALT;
            default: decoded_instruction = I_NOP;
        endcase
    end

    // ---------------- ALU ----------------
    always_comb begin
        a_op = rd(ir[3:2], regs[ir[3:2]]);
        // MOVE is executed as A | 0 so the control unit can reuse the OR path.
        b_op = (decoded_instruction == I_MOVE) ? 16'h0000 : rd(ir[1:0], regs[ir[1:0]]);
        sum  = {1'b0, a_op} + {1'b0, b_op};
        diff = {1'b0, a_op} - {1'b0, b_op};   // diff[16] is the borrow (A < B)
        alu_res = 16'h0000;
        alu_uov = 1'b0;
        alu_sov = 1'b0;
        case (operation)
            2'b00: alu_res = a_op | b_op;
            2'b01: begin
                alu_res = sum[15:0];
                alu_uov = sum[16];
                alu_sov = (a_op[15] == b_op[15]) && (alu_res[15] != a_op[15]);
            end
            2'b10: begin
                alu_res = diff[15:0];
                alu_uov = diff[16];
                alu_sov = (a_op[15] != b_op[15]) && (alu_res[15] != a_op[15]);
            end
            default: alu_res = a_op & b_op;
        endcase
    end

    // Register write source/destination follow c_sel.
    always_comb begin
        wr_idx  = c_sel ? ir[5:4] : ir[6:5];
        wr_data = c_sel ? alu_res : data_in;
    end

    // ---------------- state ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc                <= 5'd0;
            ir                <= 16'h0000;
            for (int i = 0; i < 4; i++) regs[i] <= 16'h0000;
            zero_op           <= 1'b0;
            neg_op            <= 1'b0;
            unsigned_overflow <= 1'b0;
            signed_overflow   <= 1'b0;
        end else begin
            if (pc_enable)
                pc <= branch ? ir[4:0] : pc + 5'd1;   // 5-bit add wraps 31 -> 0
            if (ir_enable)
                ir <= data_in;
            if (write_reg_enable && decoded_instruction != I_STORE) begin
`ifdef DATA_PATH_R0_ZERO_EN
                if (wr_idx != 2'd0) regs[wr_idx] <= wr_data;
`else
                regs[wr_idx] <= wr_data;
`endif
            end
            if (flags_reg_enable) begin
                zero_op           <= (alu_res == 16'h0000);
                neg_op            <= alu_res[15];
                unsigned_overflow <= alu_uov;
                signed_overflow   <= alu_sov;
            end
        end
    end

    // ---------------- outputs ----------------
    assign ram_addr = addr_sel ? ir[4:0] : pc;
    assign data_out = rd(ir[6:5], regs[ir[6:5]]);

endmodule

// File: tb/tb_data_path.sv
// Directed testbench for data_path: hand-computed vectors from the test plan.
module tb_data_path;
    import k_and_s_pkg::*;

    logic clk = 1'b0;
    logic rst_n, branch, pc_enable, ir_enable, write_reg_enable;
    logic addr_sel, c_sel, flags_reg_enable;
    logic [1:0] operation;
    logic [15:0] data_in;
    logic [4:0] ram_addr;
    logic [15:0] data_out;
    decoded_instruction_type decoded_instruction;
    logic zero_op, neg_op, unsigned_overflow, signed_overflow;

    int n_chk = 0;
    int n_err = 0;

    data_path dut (
        .clk(clk), .rst_n(rst_n), .branch(branch), .pc_enable(pc_enable),
        .ir_enable(ir_enable), .write_reg_enable(write_reg_enable),
        .addr_sel(addr_sel), .c_sel(c_sel), .operation(operation),
        .flags_reg_enable(flags_reg_enable), .data_in(data_in),
        .ram_addr(ram_addr), .data_out(data_out),
        .decoded_instruction(decoded_instruction), .zero_op(zero_op),
        .neg_op(neg_op), .unsigned_overflow(unsigned_overflow),
        .signed_overflow(signed_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ir(input logic [15:0] v);
        ir_enable = 1'b1;
        data_in   = v;
        tick();
        ir_enable = 1'b0;
    endtask

    // Write v into register r via a LOAD-style write from data_in.
    task automatic wr_reg(input logic [1:0] r, input logic [15:0] v);
        set_ir(16'h0100 | (16'(r) << 5));
        c_sel = 1'b0;
        data_in = v;
        write_reg_enable = 1'b1;
        tick();
        write_reg_enable = 1'b0;
    endtask

    // Point IR[6:5] at register r so data_out shows it.
    task automatic sel_reg(input logic [1:0] r);
        set_ir(16'h0100 | (16'(r) << 5));
    endtask

    task automatic chk_flags(input string tag, input logic [3:0] exp_zncv);
        chk({tag, ".zero"}, 32'(zero_op), 32'(exp_zncv[3]));
        chk({tag, ".neg"},  32'(neg_op),  32'(exp_zncv[2]));
        chk({tag, ".uov"},  32'(unsigned_overflow), 32'(exp_zncv[1]));
        chk({tag, ".sov"},  32'(signed_overflow),   32'(exp_zncv[0]));
    endtask

    initial begin
        rst_n = 1'b0; branch = 1'b0; pc_enable = 1'b0; ir_enable = 1'b0;
        write_reg_enable = 1'b0; addr_sel = 1'b0; c_sel = 1'b0;
        operation = 2'b00; flags_reg_enable = 1'b0; data_in = 16'h0000;

        // Reset, then release with nothing enabled
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst.ram_addr", 32'(ram_addr), 32'd0);
        chk("rst.data_out", 32'(data_out), 32'd0);
        chk("rst.dec", 32'(decoded_instruction), 32'(I_NOP));
        chk_flags("rst", 4'b0000);

        // LOAD R1 from address 5
        set_ir(16'h0125);
        addr_sel = 1'b1;
        #1;
        chk("load.ram_addr", 32'(ram_addr), 32'd5);
        chk("load.dec", 32'(decoded_instruction), 32'(I_LOAD));
        data_in = 16'hBEEF; c_sel = 1'b0; write_reg_enable = 1'b1;
        tick();
        write_reg_enable = 1'b0;
        chk("load.data_out", 32'(data_out), 32'hBEEF);

        // ADD R3 = R1 + R2 : 0x7FFF + 1
        wr_reg(2'd1, 16'h7FFF);
        wr_reg(2'd2, 16'h0001);
        set_ir(16'h0436);
        chk("add.dec", 32'(decoded_instruction), 32'(I_ADD));
        operation = 2'b01; c_sel = 1'b1; write_reg_enable = 1'b1; flags_reg_enable = 1'b1;
        tick();
        write_reg_enable = 1'b0; flags_reg_enable = 1'b0;
        chk_flags("add", 4'b0101);
        sel_reg(2'd3);
        chk("add.r3", 32'(data_out), 32'h8000);

        // SUB R1 = R1 - R2 : 5 - 5, then 0 - 1
        wr_reg(2'd1, 16'h0005);
        wr_reg(2'd2, 16'h0005);
        set_ir(16'h0516);
        operation = 2'b10; c_sel = 1'b1; write_reg_enable = 1'b1; flags_reg_enable = 1'b1;
        tick();
        write_reg_enable = 1'b0; flags_reg_enable = 1'b0;
        chk_flags("sub0", 4'b1000);
        sel_reg(2'd1);
        chk("sub0.r1", 32'(data_out), 32'h0000);
        wr_reg(2'd2, 16'h0001);
        set_ir(16'h0516);
        c_sel = 1'b1; write_reg_enable = 1'b1; flags_reg_enable = 1'b1;
        tick();
        write_reg_enable = 1'b0; flags_reg_enable = 1'b0;
        chk_flags("sub1", 4'b0110);
        sel_reg(2'd1);
        chk("sub1.r1", 32'(data_out), 32'hFFFF);
        // Flags must hold with flags_reg_enable low across later ALU activity
        operation = 2'b00;
        tick();
        chk_flags("hold", 4'b0110);

        // PC: branch to 31, wrap to 0, fetch+advance together, branch to 20
        addr_sel = 1'b0;
        set_ir(16'h081F);
        branch = 1'b1; pc_enable = 1'b1;
        tick();
        chk("pc.31", 32'(ram_addr), 32'd31);
        branch = 1'b0;
        tick();
        pc_enable = 1'b0;
        chk("pc.wrap", 32'(ram_addr), 32'd0);
        pc_enable = 1'b1; ir_enable = 1'b1; data_in = 16'h0814;
        tick();
        pc_enable = 1'b0; ir_enable = 1'b0;
        chk("pcir.pc", 32'(ram_addr), 32'd1);
        chk("pcir.dec", 32'(decoded_instruction), 32'(I_BRANCH));
        tick();
        chk("pc.hold", 32'(ram_addr), 32'd1);
        branch = 1'b1; pc_enable = 1'b1;
        tick();
        branch = 1'b0; pc_enable = 1'b0;
        chk("pc.br20", 32'(ram_addr), 32'd20);

        // STORE R2 with write strobe high: register file untouched (R2 = 1)
        set_ir(16'h0240);
        chk("st.dec", 32'(decoded_instruction), 32'(I_STORE));
        c_sel = 1'b0; data_in = 16'hDEAD; write_reg_enable = 1'b1;
        tick();
        write_reg_enable = 1'b0;
        chk("st.r2", 32'(data_out), 32'h0001);

        // R0 write
        wr_reg(2'd0, 16'h1234);
        sel_reg(2'd0);
`ifdef DATA_PATH_R0_ZERO_EN
        chk("r0", 32'(data_out), 32'h0000);
`else
        chk("r0", 32'(data_out), 32'h1234);
`endif

        // Remaining decodes
        set_ir(16'hFF00);
        chk("dec.halt", 32'(decoded_instruction), 32'(I_HALT));
        set_ir(16'h0F00);
        chk("dec.nop", 32'(decoded_instruction), 32'(I_NOP));
        set_ir(16'h0300);
        chk("dec.move", 32'(decoded_instruction), 32'(I_MOVE));

        // Reset beats simultaneous enables
        wr_reg(2'd1, 16'h4444);
        set_ir(16'h0120);
        rst_n = 1'b0; pc_enable = 1'b1; ir_enable = 1'b1; data_in = 16'h0425;
        write_reg_enable = 1'b1; flags_reg_enable = 1'b1; operation = 2'b10;
        tick();
        rst_n = 1'b1; pc_enable = 1'b0; ir_enable = 1'b0;
        write_reg_enable = 1'b0; flags_reg_enable = 1'b0;
        chk("rst2.ram_addr", 32'(ram_addr), 32'd0);
        chk("rst2.data_out", 32'(data_out), 32'd0);
        chk("rst2.dec", 32'(decoded_instruction), 32'(I_NOP));
        chk_flags("rst2", 4'b0000);
        sel_reg(2'd1);
        chk("rst2.r1", 32'(data_out), 32'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
